pipe_run_ctrl: RTL and testbench

Run/step controller for the five-stage `pipeline` core on the board. It debounces the single push-button `key` and turns it into a pipeline-wide clock enable `pipe_en`. A short press advances the core by exactly one cycle; a long press lets it free-run, optionally at a divided rate so the FND/LED display stays readable. A halt request from the write-back stage freezes the core permanently until reset.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/key_debounce.sv | 57 +++++
 rtl/pipe_run_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_run_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run/step controller: FSM state
// encoding and its width, used by the controller and the display decoder.
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    PAUSE  = 2'd0,
    STEP   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } run_state_t;

  // True for the states in which the pipeline may be clocked at all.
  function automatic logic state_can_enable(input run_state_t s);
    return (s == STEP) || (s == RUN);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: two-flop synchronizer, a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES steady cycles, and one-cycle
// pulses on the rising and falling edges of the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_db,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] stable_cnt;
  logic             key_db_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= key;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only once it has differed from key_db for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
      key_db     <= 1'b0;
      key_db_d   <= 1'b0;
    end else begin
      key_db_d <= key_db;
      if (sync_b == key_db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        key_db     <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  // Edge pulses are decoded from the debounced level and its one-cycle delay.
  assign key_press   = key_db & ~key_db_d;
  assign key_release = ~key_db & key_db_d;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/step controller for the five-stage pipeline. A short button press
// advances the core by one cycle, a long press lets it free-run (optionally
// at a divided rate), and a halt request from write-back freezes it until reset.
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LONG_CYCLES     = 100,
  parameter int RUN_DIV         = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key,
  input  logic        halt_req,
  output logic        pipe_en,
  output logic        run_led,
  output logic        halted,
  output logic [31:0] step_cnt
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int DIV_W  = $clog2(RUN_DIV + 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);

  logic              key_db;
  logic              key_press;
  logic              key_release;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              consumed;
  run_state_t        state;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .key_db     (key_db),
    .key_press  (key_press),
    .key_release(key_release)
  );

  // Measure how long the debounced key has been held, saturating at the long-press length.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (key_press) begin
      hold_cnt <= '0;
    end else if (key_db && (hold_cnt != HOLD_LONG)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

  // Run/step FSM with the run-rate divider and the press-consumed flag.
  // Halt beats every key event; a press that enters or leaves RUN marks
  // itself consumed so its release never turns into a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PAUSE;
      div_cnt  <= '0;
      consumed <= 1'b0;
    end else begin
      if (key_release) begin
        consumed <= 1'b0;
      end
      case (state)
        PAUSE: begin
          if (halt_req) begin
            state <= HALTED;
          end else if (key_release && (hold_cnt < HOLD_LONG) && !consumed) begin
            state <= STEP;
          end else if (hold_cnt == HOLD_LONG) begin
            state    <= RUN;
            div_cnt  <= '0;
            consumed <= 1'b1;
          end else begin
            state <= PAUSE;
          end
        end
        STEP: begin
          if (halt_req) begin
            state <= HALTED;
          end else begin
            state <= PAUSE;
          end
        end
        RUN: begin
          if (halt_req) begin
            state <= HALTED;
          end else if (key_press) begin
            state    <= PAUSE;
            consumed <= 1'b1;
          end else begin
            state   <= RUN;
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : (div_cnt + DIV_W'(1));
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= PAUSE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state and divider registers.
  assign pipe_en = state_can_enable(state) &&
                   ((state == STEP) || (div_cnt == DIV_LAST));
  assign run_led = (state == RUN);
  assign halted  = (state == HALTED);

  // Count every cycle in which the pipeline was enabled, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= 32'd0;
    end else if (pipe_en) begin
      step_cnt <= step_cnt + 32'd1;
    end else begin
      step_cnt <= step_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl. Two instances share all inputs:
// one free-runs at full rate, the other at RUN_DIV=4. Each driven cycle pushes
// the expected outputs of that cycle to a scoreboard; a negedge monitor pops
// and compares.
module tb_pipe_run_ctrl;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        key      = 1'b0;
  logic        halt_req = 1'b0;
  logic        pe1, run1, hlt1;
  logic        pe4, run4, hlt4;
  logic [31:0] cnt1, cnt4;

  always #5 clk = ~clk;

  pipe_run_ctrl #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .RUN_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .key(key), .halt_req(halt_req),
    .pipe_en(pe1), .run_led(run1), .halted(hlt1), .step_cnt(cnt1)
  );

  pipe_run_ctrl #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .RUN_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .key(key), .halt_req(halt_req),
    .pipe_en(pe4), .run_led(run4), .halted(hlt4), .step_cnt(cnt4)
  );

  typedef struct {
    bit chk;
    bit pe1; bit run1; bit hlt1; int cnt1;
    bit pe4; bit run4; bit hlt4; int cnt4;
  } exp_t;

  typedef struct {
    int hold_len;
    bit bounce;
    bit exp_step;
    bit exp_run;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc_no = 0;

  task automatic check(input string name, input longint act, input longint want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc_no);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk) begin
        check("pipe_en_div1",  pe1,  mon_e.pe1);
        check("run_led_div1",  run1, mon_e.run1);
        check("halted_div1",   hlt1, mon_e.hlt1);
        check("step_cnt_div1", cnt1, mon_e.cnt1);
        check("pipe_en_div4",  pe4,  mon_e.pe4);
        check("run_led_div4",  run4, mon_e.run4);
        check("halted_div4",   hlt4, mon_e.hlt4);
        check("step_cnt_div4", cnt4, mon_e.cnt4);
      end
    end
  end

  function automatic exp_t mk(bit c, bit p1, bit r1, bit h1, int c1,
                              bit p4, bit r4, bit h4, int c4);
    exp_t e;
    e.chk = c;
    e.pe1 = p1; e.run1 = r1; e.hlt1 = h1; e.cnt1 = c1;
    e.pe4 = p4; e.run4 = r4; e.hlt4 = h4; e.cnt4 = c4;
    return e;
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Key rises in cycle 0 and is held L cycles: release pulse at L+6, step at L+7.
  function automatic exp_t step_exp(int k, int len, bit stepped, int b1, int b4);
    bit pe;
    int c;
    pe = stepped && (k == len + 7);
    c  = (stepped && (k >= len + 8)) ? 1 : 0;
    return mk(1'b1, pe, 1'b0, 1'b0, b1 + c, pe, 1'b0, 1'b0, b4 + c);
  endfunction

  // RUN occupies cycles first..last; optionally HALTED afterwards.
  function automatic exp_t run_exp(int k, int first, int last, bit halt_after, int b1, int b4);
    bit on;
    bit hl;
    bit p4;
    int n;
    on = (k >= first) && (k <= last);
    hl = halt_after && (k > last);
    n  = clampi(k - first, 0, last - first + 1);
    p4 = on && (((k - first) % 4) == 3);
    return mk(1'b1, on, on, hl, b1 + n, p4, on, hl, b4 + n / 4);
  endfunction

  task automatic drive(input bit k, input bit h, input bit r, input exp_t e);
    @(posedge clk);
    #1;
    key      = k;
    halt_req = h;
    reset    = r;
    cyc_no++;
    sb.push_back(e);
  endtask

  initial begin
    int  b1;
    int  b4;
    bit  kv;
    exp_t zero_e;

    vecs[0] = '{hold_len: 0,  bounce: 1'b1, exp_step: 1'b0, exp_run: 1'b0};
    vecs[1] = '{hold_len: 3,  bounce: 1'b0, exp_step: 1'b0, exp_run: 1'b0};
    vecs[2] = '{hold_len: 4,  bounce: 1'b0, exp_step: 1'b1, exp_run: 1'b0};
    vecs[3] = '{hold_len: 10, bounce: 1'b0, exp_step: 1'b1, exp_run: 1'b0};
    vecs[4] = '{hold_len: 20, bounce: 1'b0, exp_step: 1'b1, exp_run: 1'b0};
    vecs[5] = '{hold_len: 21, bounce: 1'b0, exp_step: 1'b0, exp_run: 1'b1};
    vecs[6] = '{hold_len: 40, bounce: 1'b0, exp_step: 1'b0, exp_run: 1'b1};

    zero_e = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    b1 = 0;
    b4 = 0;

    // Reset state, held and just after release.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, zero_e);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, zero_e);

    // Table: bounce, sub-debounce pulse, short presses, long-press boundary.
    // Long vectors stop RUN with a 10-cycle press starting at cycle 61 (press pulse 67).
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 90; k++) begin
        if (vecs[v].bounce) kv = (k < 12) && (((k / 2) % 2) == 0);
        else                kv = (k < vecs[v].hold_len) ||
                                 (vecs[v].exp_run && (k >= 61) && (k < 71));
        if (vecs[v].exp_run) drive(kv, 1'b0, 1'b0, run_exp(k, 28, 67, 1'b0, b1, b4));
        else                 drive(kv, 1'b0, 1'b0, step_exp(k, vecs[v].hold_len, vecs[v].exp_step, b1, b4));
      end
      if (vecs[v].exp_step) begin
        b1 += 1;
        b4 += 1;
      end else if (vecs[v].exp_run) begin
        b1 += 40;
        b4 += 10;
      end
    end

    // Halt during RUN at cycle 35, then presses that must be ignored, then reset.
    for (int k = 0; k < 80; k++) begin
      kv = (k < 40) || ((k >= 50) && (k < 60));
      drive(kv, (k >= 35) && (k <= 37), 1'b0, run_exp(k, 28, 35, 1'b1, b1, b4));
    end
    drive(1'b0, 1'b0, 1'b1, run_exp(80, 28, 35, 1'b1, b1, b4));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, zero_e);

    // Press and halt in the same RUN cycle: HALTED wins over PAUSE.
    for (int k = 0; k < 90; k++) begin
      kv = (k < 40) || ((k >= 61) && (k < 71));
      drive(kv, k == 67, 1'b0, run_exp(k, 28, 67, 1'b1, 0, 0));
    end
    drive(1'b0, 1'b0, 1'b1, run_exp(90, 28, 67, 1'b1, 0, 0));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, zero_e);

    // Reset in the release cycle of a short press: no step may follow.
    for (int k = 0; k < 31; k++) begin
      drive(k < 10, 1'b0, k == 16, zero_e);
    end

    // Ordinary short press after that reset still steps once.
    for (int k = 0; k < 30; k++) begin
      drive(k < 10, 1'b0, 1'b0, step_exp(k, 10, 1'b1, 0, 0));
    end

    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0));
    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0));
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
